fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 40 ++++
 rtl/fetch_unit_bht.sv | 60 ++++++
 rtl/fetch_unit.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: reset vector, instruction width
// and the 2-bit branch counter encoding with its update helpers.
package fetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = INST_W / 8;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_update(ctr_e c, logic taken);
    ctr_e n;
    n = c;
    unique case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = CTR_WNT;
    endcase
    return n;
  endfunction

  // A fresh or reallocated entry starts one step off the taken/not-taken boundary.
  function automatic ctr_e ctr_init(logic taken);
    return taken ? CTR_WT : CTR_WNT;
  endfunction

  function automatic logic ctr_predicts_taken(ctr_e c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Direct-mapped branch target / history table: combinational read port and
// one synchronous write port used by EX to train resolved branches.
module bht
  import fetch_unit_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = XLEN - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_taken,
  output logic [XLEN-1:0]   rd_target,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_taken,
  input  logic [XLEN-1:0]   wr_target
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];

  logic wr_hit;
  logic wr_tgt_en;
  ctr_e wr_ctr;

  // Reads see the table as it was before this cycle's write.
  assign rd_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag)
                     && ctr_predicts_taken(ctr_q[rd_idx]);
  assign rd_target = target_q[rd_idx];

  always_comb begin
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_ctr    = wr_hit ? ctr_update(ctr_q[wr_idx], wr_taken) : ctr_init(wr_taken);
    wr_tgt_en = !wr_hit || wr_taken;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      ctr_q[wr_idx]   <= wr_ctr;
      if (wr_tgt_en) target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and a dynamic
// branch predictor lookup on the current PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BHT_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fStall,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  // Training port is valid-only: EX presents one resolved branch per cycle
  // while upd_valid is high and the table always accepts it (no ready).
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [XLEN-1:0]   pc_f,
  output logic [INST_W-1:0] inst_f,
  output logic              br_pred_f
);

  localparam int TAG_W = XLEN - BHT_IDX_W - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            unused_upd_lsb;

  assign imem_addr      = pc_q;
  assign pc_f           = pc_q;
  assign inst_f         = imem_rdata;
  assign br_pred_f      = pred_taken;
  assign unused_upd_lsb = ^upd_pc[1:0];

  bht #(
    .IDX_W (BHT_IDX_W),
    .TAG_W (TAG_W)
  ) u_bht (
    .clk       (clk),
    .rstn      (rstn),
    .rd_idx    (pc_q[BHT_IDX_W+1:2]),
    .rd_tag    (pc_q[XLEN-1:BHT_IDX_W+2]),
    .rd_taken  (pred_taken),
    .rd_target (pred_target),
    .wr_en     (upd_valid),
    .wr_idx    (upd_pc[BHT_IDX_W+1:2]),
    .wr_tag    (upd_pc[XLEN-1:BHT_IDX_W+2]),
    .wr_taken  (upd_taken),
    .wr_target (upd_target)
  );

  // A correction from EX outranks a stall: the stalled instruction is on the wrong path.
  always_comb begin
    pc_next = pc_q + XLEN'(INST_BYTES);
    if (redirect)        pc_next = redirect_pc;
    else if (fStall)     pc_next = pc_q;
    else if (pred_taken) pc_next = pred_target;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_next;
  end

endmodule
